// File: rtl/sync_register_file_if.sv
// sync_register_file_if
//
// Bundles the data/control/status signals of sync_register_file so the
// register bank can be connected as one port. Clock and reset stay outside.
//
// Parameters
//   W : data width in bits
//   A : address width (depth = 2**A)
//
// Signals (directions from the register file's point of view)
//   Data               in   W  write data
//   Destination_Select in   A  write address
//   Write_Enable       in   1  write request
//   Source_Select_0    in   A  read address, port 0
//   Source_Select_1    in   A  read address, port 1
//   Read_Enable        in   1  read request for both ports
//   Clear_Start        in   1  request to zero every entry
//   Busy               out  1  high while the clear sequence runs
//   Out_0              out  W  registered read data, port 0
//   Out_1              out  W  registered read data, port 1
//   Valid              out  1  Out_0/Out_1 were loaded by the preceding edge
//
// Modports
//   master : the datapath driving requests
//   slave  : the register file
interface sync_register_file_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 3
) ();

  logic [W-1:0] Data;
  logic [A-1:0] Destination_Select;
  logic         Write_Enable;
  logic [A-1:0] Source_Select_0;
  logic [A-1:0] Source_Select_1;
  logic         Read_Enable;
  logic         Clear_Start;
  logic         Busy;
  logic [W-1:0] Out_0;
  logic [W-1:0] Out_1;
  logic         Valid;

  modport master (
    output Data,
    output Destination_Select,
    output Write_Enable,
    output Source_Select_0,
    output Source_Select_1,
    output Read_Enable,
    output Clear_Start,
    input  Busy,
    input  Out_0,
    input  Out_1,
    input  Valid
  );

  modport slave (
    input  Data,
    input  Destination_Select,
    input  Write_Enable,
    input  Source_Select_0,
    input  Source_Select_1,
    input  Read_Enable,
    input  Clear_Start,
    output Busy,
    output Out_0,
    output Out_1,
    output Valid
  );

endinterface

// File: rtl/sync_register_file.sv
// sync_register_file
//
// General-purpose register bank: 2**A entries of W bits, one write port and
// two registered read ports sharing one read enable. A read sampled on an
// edge shows its data on Out_0/Out_1 after that edge, with Valid high for
// exactly that one cycle; otherwise the outputs hold. A Clear_Start pulse
// runs a sequencer that zeroes one entry per cycle (Busy high for exactly
// 2**A cycles); reads and writes arriving while it runs are dropped.
//
// Parameters
//   W        : data width (>= 1)
//   A        : address width (>= 1), depth N = 2**A
//   ZERO_REG : 1 = entry 0 reads as zero and writes to it are discarded
//
// Compile-time option
//   REGFILE_BYPASS_EN : when defined, a read of the address written on the
//                       same edge returns the new data (write-first);
//                       otherwise it returns the old contents (read-first).
//
// Ports
//   CLK   in  clock, all state changes on the rising edge
//   Reset in  asynchronous active-low reset
//   bus   sync_register_file_if.slave, see the interface for signal list
module sync_register_file #(
  parameter int unsigned W        = 8,
  parameter int unsigned A        = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic                 CLK,
  input logic                 Reset,
  sync_register_file_if.slave bus
);

  localparam int unsigned N = 1 << A;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e       state_q, state_d;
  logic [A-1:0] clr_cnt_q, clr_cnt_d;
  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  logic [W-1:0] out0_q, out0_d;
  logic [W-1:0] out1_q, out1_d;
  logic         valid_q, valid_d;

  logic         idle;
  logic         wr_en;
  logic         rd_en;
  logic [A-1:0] rd_sel [2];
  logic [W-1:0] rd_data [2];

  assign idle  = (state_q == StIdle);
  // Writes to the hard-wired zero entry are dropped here so the entry itself
  // never holds a nonzero value.
  assign wr_en = idle && bus.Write_Enable &&
                 !(ZERO_REG && (bus.Destination_Select == '0));
  assign rd_en = idle && bus.Read_Enable;

  assign rd_sel[0] = bus.Source_Select_0;
  assign rd_sel[1] = bus.Source_Select_1;

  // Read data selection per port: array contents, optionally overridden by
  // the same-edge write data, and finally forced to zero for entry 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (rd_sel[p] == bus.Destination_Select)) begin
        rd_data[p] = bus.Data;
      end
`endif
      if (ZERO_REG && (rd_sel[p] == '0)) begin
        rd_data[p] = '0;
      end
    end
  end

  // Next-state: sequencer, array contents and read registers.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d     = mem_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          mem_d[bus.Destination_Select] = bus.Data;
        end
        if (rd_en) begin
          out0_d  = rd_data[0];
          out1_d  = rd_data[1];
          valid_d = 1'b1;
        end
        // Accesses on the start edge still happen; the sweep zeroes them later.
        if (bus.Clear_Start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        // Clear_Start is ignored here: no restart, no extension.
        mem_d[clr_cnt_q] = '0;
        clr_cnt_d        = clr_cnt_q + A'(1);
        if (&clr_cnt_q) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      mem_q     <= '{default: '0};
      out0_q    <= '0;
      out1_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      mem_q     <= mem_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      valid_q   <= valid_d;
    end
  end

  // All outputs come straight from flops (Busy is a decode of the state flop).
  assign bus.Busy  = (state_q == StClear);
  assign bus.Out_0 = out0_q;
  assign bus.Out_1 = out1_q;
  assign bus.Valid = valid_q;

endmodule

// File: tb/tb_sync_register_file.sv
// Bench for sync_register_file: two instances (ZERO_REG = 0 and 1) driven
// with identical stimulus and compared against a per-instance reference model.
module tb_sync_register_file;

  localparam int W = 8;
  localparam int A = 3;
  localparam int N = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_register_file_if #(.W(W), .A(A)) bus0 ();
  sync_register_file_if #(.W(W), .A(A)) bus1 ();

  sync_register_file #(.W(W), .A(A), .ZERO_REG(1'b0)) dut0 (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus0)
  );

  sync_register_file #(.W(W), .A(A), .ZERO_REG(1'b1)) dut1 (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, index 0 = dut0, 1 = dut1 (zero register).
  logic [7:0] mdl [2][N];
  int         clr_left [2];
  logic [7:0] e_out0 [2];
  logic [7:0] e_out1 [2];
  logic       e_valid [2];

  logic [17:0] obs [2];
  assign obs[0] = {bus0.Busy, bus0.Valid, bus0.Out_0, bus0.Out_1};
  assign obs[1] = {bus1.Busy, bus1.Valid, bus1.Out_0, bus1.Out_1};

  function automatic logic [17:0] exp_vec(input int i);
    return {(clr_left[i] != 0), e_valid[i], e_out0[i], e_out1[i]};
  endfunction

  function automatic logic [7:0] model_read(input int i, input bit zr, input bit wr_ok,
                                            input logic [2:0] wa, input logic [7:0] wd,
                                            input logic [2:0] s);
    if (zr && s == 3'd0) return 8'h00;
    if (Bypass && wr_ok && s == wa) return wd;
    return mdl[i][s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < N; a++) mdl[i][a] = 8'h00;
      clr_left[i] = 0;
      e_out0[i]   = 8'h00;
      e_out1[i]   = 8'h00;
      e_valid[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                            input bit re, input logic [2:0] s0, input logic [2:0] s1,
                            input bit cs);
    for (int i = 0; i < 2; i++) begin
      bit zr;
      bit wr_ok;
      zr = (i == 1);
      if (clr_left[i] != 0) begin
        mdl[i][N - clr_left[i]] = 8'h00;
        clr_left[i]--;
        e_valid[i] = 1'b0;
      end else begin
        wr_ok = we && !(zr && wa == 3'd0);
        if (re) begin
          e_out0[i] = model_read(i, zr, wr_ok, wa, wd, s0);
          e_out1[i] = model_read(i, zr, wr_ok, wa, wd, s1);
        end
        e_valid[i] = re;
        if (wr_ok) mdl[i][wa] = wd;
        if (cs) clr_left[i] = N;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, sample at +1.
  task automatic cycle(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                       input bit re, input logic [2:0] s0, input logic [2:0] s1,
                       input bit cs);
    bus0.Write_Enable = we; bus0.Destination_Select = wa; bus0.Data = wd;
    bus0.Read_Enable = re;  bus0.Source_Select_0 = s0;    bus0.Source_Select_1 = s1;
    bus0.Clear_Start = cs;
    bus1.Write_Enable = we; bus1.Destination_Select = wa; bus1.Data = wd;
    bus1.Read_Enable = re;  bus1.Source_Select_0 = s0;    bus1.Source_Select_1 = s1;
    bus1.Clear_Start = cs;
    @(posedge clk);
    model_step(we, wa, wd, re, s0, s1, cs);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic random_cycle(input int clear_odds);
    cycle(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
          3'($urandom), 3'($urandom), (clear_odds > 0) && ($urandom_range(0, clear_odds) == 0));
  endtask

  task automatic test_reset();
    idle_cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== exp_vec(i)) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) random_cycle(0);
    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== exp_vec(i)) begin
        miscompares++;
        $display("FAIL reset_async dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 1'b0);
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'hA5, 8'hA5}) begin
      miscompares++;
      $display("FAIL reset_then_read: got %h want %h", obs[0], {1'b0, 1'b1, 8'hA5, 8'hA5});
    end
    idle_cycle();
    vectors++;
    if (obs[0] !== {1'b0, 1'b0, 8'hA5, 8'hA5}) begin
      miscompares++;
      $display("FAIL reset_read_hold: got %h want %h", obs[0], {1'b0, 1'b0, 8'hA5, 8'hA5});
    end
  endtask

  task automatic test_write_read();
    for (int a = 0; a < N; a++) cycle(1'b1, 3'(a), 8'((a + 1) * 8'h11), 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7, 1'b0);
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'h11, 8'h88}) begin
      miscompares++;
      $display("FAIL read_0_7: got %h want %h", obs[0], {1'b0, 1'b1, 8'h11, 8'h88});
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== exp_vec(i)) begin
        miscompares++;
        $display("FAIL read_0_7_model dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd5, 1'b0);
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'h33, 8'h66}) begin
      miscompares++;
      $display("FAIL read_2_5: got %h want %h", obs[0], {1'b0, 1'b1, 8'h33, 8'h66});
    end
  endtask

  task automatic test_bypass();
    cycle(1'b1, 3'd4, 8'h55, 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b1, 3'd4, 8'h5C, 1'b1, 3'd4, 3'd1, 1'b0);
    vectors++;
    if (obs[0][15:8] !== (Bypass ? 8'h5C : 8'h55)) begin
      miscompares++;
      $display("FAIL same_edge_rw: got %h want %h", obs[0][15:8], (Bypass ? 8'h5C : 8'h55));
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== exp_vec(i)) begin
        miscompares++;
        $display("FAIL same_edge_model dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 1'b0);
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'h5C, 8'h5C}) begin
      miscompares++;
      $display("FAIL reread_after_rw: got %h want %h", obs[0], {1'b0, 1'b1, 8'h5C, 8'h5C});
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    busy_cycles = 0;
    for (int a = 0; a < N; a++) cycle(1'b1, 3'(a), 8'($urandom_range(1, 255)), 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1);
    if (bus0.Busy === 1'b1) busy_cycles++;
    for (int k = 0; k < 9; k++) begin
      cycle(k < 5, 3'd2, 8'hFF, 1'($urandom), 3'($urandom), 3'($urandom), k == 3);
      if (bus0.Busy === 1'b1) busy_cycles++;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL clear_seq dut%0d cyc%0d: got %h want %h", i, k, obs[i], exp_vec(i));
        end
      end
    end
    vectors++;
    if (busy_cycles !== 8) begin
      miscompares++;
      $display("FAIL busy_length: got %0d want 8", busy_cycles);
    end
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 3'(N - 1 - a), 1'b0);
      vectors++;
      if (obs[0] !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
        miscompares++;
        $display("FAIL cleared_addr%0d: got %h want %h", a, obs[0], {1'b0, 1'b1, 8'h00, 8'h00});
      end
    end
  endtask

  task automatic test_clear_reset();
    for (int a = 0; a < N; a++) cycle(1'b1, 3'(a), 8'($urandom_range(1, 255)), 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) idle_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (bus0.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_reset: got %b want 0", bus0.Busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < N; a += 2) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 3'(a + 1), 1'b0);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL abort_read%0d dut%0d: got %h want %h", a, i, obs[i], exp_vec(i));
        end
      end
    end
    cycle(1'b1, 3'd6, 8'h3C, 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 1'b0);
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'h3C, 8'h00}) begin
      miscompares++;
      $display("FAIL after_abort_rw: got %h want %h", obs[0], {1'b0, 1'b1, 8'h3C, 8'h00});
    end
  endtask

  task automatic test_zero_reg();
    cycle(1'b1, 3'd0, 8'h7E, 1'b0, 3'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0, 1'b0);
    vectors++;
    if (obs[1] !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL zero_reg_read: got %h want %h", obs[1], {1'b0, 1'b1, 8'h00, 8'h00});
    end
    vectors++;
    if (obs[0] !== {1'b0, 1'b1, 8'h7E, 8'h7E}) begin
      miscompares++;
      $display("FAIL plain_reg0_read: got %h want %h", obs[0], {1'b0, 1'b1, 8'h7E, 8'h7E});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      random_cycle(30);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL random cyc%0d dut%0d: got %h want %h", k, i, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_clear_reset();
    test_zero_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/sync_register_file.md
# sync_register_file

Parametrised two-read/one-write register file with registered (one-cycle) read ports, a read-valid strobe, an optional hard-wired zero register and a sequenced bulk-clear engine. Used as the general-purpose register bank of the lab datapath. Generalises the 8×W register file to 2^A entries and adds synchronous read timing, Busy/clear handshaking and compile-time write-to-read forwarding.

## Interface
- W, default 8: data width in bits (≥1).
- A, default 3: address width; depth N = 2^A entries (A ≥ 1).
- ZERO_REG, default 0: 1 = entry 0 always reads 0 and writes to it are discarded.

- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Data  input  W  write data.
- Destination_Select  input  A  write address.
- Write_Enable  input  1  write request, sampled at rising edge.
- Source_Select_0  input  A  read address, port 0.
- Source_Select_1  input  A  read address, port 1.
- Read_Enable  input  1  read request for both ports, sampled at rising edge.
- Clear_Start  input  1  request to zero all entries, sampled at rising edge.
- Busy  output  1  high while clear sequence runs.
- Out_0  output  W  registered read data, port 0.
- Out_1  output  W  registered read data, port 1.
- Valid  output  1  one-cycle strobe: Out_0/Out_1 updated by the preceding edge.

## Operation
- Reset low (any time, asynchronous): all entries 0, Out_0 = Out_1 = 0, Valid = 0, Busy = 0, FSM IDLE, clear counter 0. Reset during CLEAR aborts the sequence; all entries are zero regardless.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR on edge with Clear_Start = 1; counter loaded 0.
  - CLEAR: each edge zeroes entry[counter], counter increments; after entry N−1 is zeroed → IDLE, counter wraps to 0.
  - Clear_Start in CLEAR: ignored (no restart, no extension).
- Write: in IDLE, edge with Write_Enable = 1 stores Data into entry[Destination_Select]. In CLEAR: write dropped, no side effects. ZERO_REG = 1 and address 0: dropped.
- Read: in IDLE, edge with Read_Enable = 1 loads Out_0 ← entry[Source_Select_0], Out_1 ← entry[Source_Select_1]; Valid = 1 for the following cycle. Both ports may select the same address. Otherwise Out_0/Out_1 hold their value, Valid = 0. In CLEAR reads are dropped, Valid = 0.
- Same-address read and write on one edge: governed by REGFILE_BYPASS_EN (see Configuration). Simultaneous write and read to different addresses: both performed.
- Edge on which Clear_Start is sampled in IDLE: a write and/or read on that same edge is still performed (FSM was IDLE); the written entry is subsequently zeroed by the sequence.
- ZERO_REG = 1: reads of address 0 return 0 on either port.

## Timing
- Read latency: 1 cycle (request at edge k → data and Valid visible after edge k, until edge k+1).
- Write latency: entry updated at edge k; a read sampled at edge k+1 returns it.
- Clear: Clear_Start sampled at edge k → Busy = 1 after edge k; entries 0..N−1 zeroed at edges k+1..k+N; Busy = 0 after edge k+N. Busy is high for exactly N cycles; first accepted access is at edge k+N+1.
- Busy, Valid, Out_* are register outputs (no combinational path from inputs).

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: read and write to the same address on the same IDLE edge → that read port loads the new Data (write-first forwarding). Not forwarded when ZERO_REG = 1 and address 0 (port still reads 0).
- Undefined: same case → port loads the old entry value (read-first); new value visible from the next read.

## Test plan
(W = 8, A = 3, ZERO_REG = 0 unless noted.)
- Reset low mid-run, then write 0xA5 to addr 3, read addr 3 on both ports → after read edge Out_0 = Out_1 = 0xA5, Valid = 1 for one cycle, then Valid = 0 and outputs hold 0xA5.
- Write 0x11..0x88 to addrs 0..7, read (0,7),(2,5) on consecutive edges → outputs (0x11,0x88) then (0x33,0x66), Valid high two consecutive cycles.
- Same edge write 0x5C to addr 4 (old 0x55) and read addr 4 → Out_0 = 0x5C with REGFILE_BYPASS_EN, 0x55 without; next read returns 0x5C either way.
- Fill all entries nonzero, pulse Clear_Start, issue write 0xFF to addr 2 and Clear_Start again during Busy → Busy high exactly 8 cycles, writes/restart ignored, then every address reads 0x00.
- Reset low at 4th cycle of CLEAR → Busy = 0 immediately, all entries read 0x00, next write/read accepted normally.
- ZERO_REG = 1: write 0x7E to addr 0, read (0,0) → Out_0 = Out_1 = 0x00, Valid = 1.
